dtcm_ahb_slave: RTL

AHB-Lite responder implementing the data tightly-coupled memory: the slave end of the core's `dtcm_*` / `mau_*` bus. It accepts single transfers from the memory access unit, stores data in an internal word array with byte-lane writes, and returns read data. It signals wait states and two-cycle ERROR responses per AHB-Lite. It sits between the core's MAU master port and the testbench/system, replacing the behavioural memory model.

---
 rtl/dtcm_ahb_slave.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dtcm_ahb_slave.sv
// ---------------------------------------------------------------------------
// dtcm_ahb_slave
//   AHB-Lite responder for the data tightly-coupled memory. Takes single
//   transfers from the memory access unit and stores them in a 32-bit word
//   array with byte-lane writes. Reads return the full, unshifted word.
//   Bad address, size or alignment gives a two-cycle ERROR response.
//
//   Optional feature macro: DTCM_WAIT_STATE_EN
//     defined   : every OKAY transfer inserts WAIT_CYCLES wait states.
//     undefined : every OKAY transfer is zero-wait; WAIT_CYCLES is ignored.
//
// Ports
//   hclk        in   clock, rising edge
//   hrst        in   synchronous active-high reset
//   hsel        in   slave select
//   haddr[31:0] in   transfer address
//   htrans[1:0] in   IDLE/BUSY/NONSEQ/SEQ
//   hwrite      in   1 = write
//   hsize[2:0]  in   0 byte, 1 half, 2 word
//   hburst, hprot, hmastlock  in  ignored
//   hwdata[31:0] in  write data (data phase, lane-aligned)
//   hready      in   bus ready; address phase sampled only when high
//   hreadyout   out  data phase completes
//   hresp       out  0 OKAY, 1 ERROR
//   hrdata[31:0] out read data (0 outside a read data phase)
// ---------------------------------------------------------------------------
module dtcm_ahb_slave #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [6:0]  hprot,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    hreadyout_q, hresp_q;
    logic                    accept, take, addr_err;
    logic [3:0]              be;
    logic [31:0]             mem [DEPTH];

`ifdef DTCM_WAIT_STATE_EN
    logic [3:0]              cnt_q, cnt_d;
`else
    logic [3:0]              unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
`endif

    // Control-only AHB attributes carry no meaning for a plain memory.
    logic unused_attr;
    assign unused_attr = ^{hburst, hprot, hmastlock};

    assign accept = hsel & hready & htrans[1];
    // A new address phase is only taken while our own data phase is not
    // stalling; this also discards addresses presented during ERR1.
    assign take   = accept && (state_q inside {ST_IDLE, ST_DATA, ST_ERR2});

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        addr_err = 1'b0;
        if (haddr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]) addr_err = 1'b1;
        if (hsize > 3'd2)                                      addr_err = 1'b1;
        if (hsize == 3'd1 && haddr[0])                         addr_err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)              addr_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
`ifdef DTCM_WAIT_STATE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_WAIT: begin
`ifdef DTCM_WAIT_STATE_EN
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (take) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
`ifdef DTCM_WAIT_STATE_EN
                        if (WAIT_CYCLES > 0) begin
                            state_d = ST_WAIT;
                            // WAIT lasts until the counter has been seen at 0.
                            cnt_d   = 4'(WAIT_CYCLES - 1);
                        end else begin
                            state_d = ST_DATA;
                        end
`else
                        state_d = ST_DATA;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
`ifdef DTCM_WAIT_STATE_EN
            cnt_q       <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            hreadyout_q <= (state_d inside {ST_IDLE, ST_DATA, ST_ERR2});
            hresp_q     <= (state_d inside {ST_ERR1, ST_ERR2});
`ifdef DTCM_WAIT_STATE_EN
            cnt_q       <= cnt_d;
`endif
            if (take) begin
                addr_q  <= haddr[ADDR_WIDTH-1:0];
                write_q <= hwrite;
                size_q  <= hsize[1:0];
            end
        end
    end

    // Byte lanes from the latched address and size (size 3 never reaches DATA).
    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // NOTE: the storage array has no reset; only control state is reset, and
    // a reset edge suppresses the commit of a write in flight.
    always_ff @(posedge hclk) begin
        if (!hrst && state_q == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[ADDR_WIDTH-1:2]][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    // Asynchronous read: a write committing on the edge that opens this read's
    // data phase is already visible, so no forwarding path is needed.
    assign hrdata    = (state_q == ST_DATA && !write_q) ? mem[addr_q[ADDR_WIDTH-1:2]] : 32'd0;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule
